// File: rtl/kbd_pkg.sv
// Shared event encoding for the keyboard/encoder event collector.
// An event byte carries a 2-bit type in the top bits and a 6-bit source index below.
package kbd_pkg;

  localparam int EV_W        = 8;
  localparam int EV_TYPE_MSB = 7;
  localparam int EV_TYPE_LSB = 6;
  localparam int EV_IDX_MSB  = 5;
  localparam int EV_IDX_LSB  = 0;
  localparam int EV_IDX_W    = EV_IDX_MSB - EV_IDX_LSB + 1;

  typedef enum logic [1:0] {
    EV_RELEASE = 2'b00,
    EV_PRESS   = 2'b01,
    EV_CW      = 2'b10,
    EV_CCW     = 2'b11
  } ev_type_t;

  function automatic logic [EV_W-1:0] make_event(input ev_type_t t,
                                                  input logic [EV_IDX_W-1:0] idx);
    logic [EV_W-1:0] ev;
    ev = '0;
    ev[EV_TYPE_MSB:EV_TYPE_LSB] = t;
    ev[EV_IDX_MSB:EV_IDX_LSB]   = idx;
    return ev;
  endfunction

endpackage

// File: rtl/kbd_debounce.sv
// One key: 2-FF synchronizer, polarity normalisation (1 = pressed) and tick-based debounce.
// accept pulses for one clk in the cycle the stable level flips.
module kbd_debounce #(
  parameter int DEB_TICKS  = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_tick,
  input  logic pin,
  output logic stable,
  output logic accept
);

  localparam logic IDLE_PIN = ACTIVE_LOW;
  localparam logic [7:0] LAST_CNT = 8'(DEB_TICKS - 1);

  logic sync1;
  logic sync2;
  logic level;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  assign level  = sync2 ^ ACTIVE_LOW;
  assign accept = scan_tick && (level != stable) && (cnt == LAST_CNT);

  // Counter only runs while the synchronised level disagrees with the accepted one
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= 8'd0;
    end else if (level == stable) begin
      cnt <= 8'd0;
    end else if (accept) begin
      stable <= level;
      cnt    <= 8'd0;
    end else if (scan_tick) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/kbd_event_collector.sv
// Panel front end: debounced keys and quadrature encoders arbitrated into an event FIFO.
// Encoder flags outrank keys; lower indices win; a full FIFO holds pending bits in place.
module kbd_event_collector
  import kbd_pkg::*;
#(
  parameter int NUM_KEYS       = 32,
  parameter int NUM_ENC        = 4,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int DEB_TICKS      = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_tick,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic [NUM_ENC-1:0]  enc_a,
  input  logic [NUM_ENC-1:0]  enc_b,
  input  logic                fifo_clr,
  input  logic                ev_rd,
  output logic [EV_W-1:0]     ev_data,
  output logic                ev_valid,
  output logic                fifo_full,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  logic [NUM_KEYS-1:0] key_stable;
  logic [NUM_KEYS-1:0] key_accept;
  logic [NUM_KEYS-1:0] pend_key;
  logic [NUM_KEYS-1:0] pend_press;

  logic [NUM_ENC-1:0] a_s1, a_s2, b_s1, b_s2, a_prev, b_prev;
  logic [NUM_ENC-1:0] step_valid, step_up, det_cw, det_ccw;
  logic [NUM_ENC-1:0] pend_cw, pend_ccw;
  logic signed [2:0]  acc [NUM_ENC];
  logic               overflow_q;

  logic                grant_found;
  logic [EV_W-1:0]     grant_event;
  logic [NUM_ENC-1:0]  clr_cw, clr_ccw;
  logic [NUM_KEYS-1:0] clr_key;
  logic                push;
  logic                pop;

  logic [EV_W-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    kbd_debounce #(
      .DEB_TICKS (DEB_TICKS),
      .ACTIVE_LOW(KEY_ACTIVE_LOW != 0)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .scan_tick(scan_tick),
      .pin      (keys[k]),
      .stable   (key_stable[k]),
      .accept   (key_accept[k])
    );
  end

  // Encoder pins idle low; prev holds last cycle's synchronised A/B for step detection
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1   <= '0;
      a_s2   <= '0;
      b_s1   <= '0;
      b_s2   <= '0;
      a_prev <= '0;
      b_prev <= '0;
    end else begin
      a_s1   <= enc_a;
      a_s2   <= a_s1;
      b_s1   <= enc_b;
      b_s2   <= b_s1;
      a_prev <= a_s2;
      b_prev <= b_s2;
    end
  end

  // Exactly one channel changing is a legal Gray step; a ^ prev_b set means A leads
  always_comb begin
    step_valid = '0;
    step_up    = '0;
    det_cw     = '0;
    det_ccw    = '0;
    for (int e = 0; e < NUM_ENC; e++) begin
      step_valid[e] = (a_s2[e] ^ a_prev[e]) ^ (b_s2[e] ^ b_prev[e]);
      step_up[e]    = a_s2[e] ^ b_prev[e];
      det_cw[e]     = step_valid[e] && step_up[e] && (acc[e] == 3'sd3);
      det_ccw[e]    = step_valid[e] && !step_up[e] && (acc[e] == -3'sd3);
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_ENC; e++) begin
      if (rst || fifo_clr) begin
        acc[e] <= 3'sd0;
      end else if (det_cw[e] || det_ccw[e]) begin
        acc[e] <= 3'sd0;
      end else if (step_valid[e]) begin
        acc[e] <= step_up[e] ? acc[e] + 3'sd1 : acc[e] - 3'sd1;
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_event = '0;
    clr_cw      = '0;
    clr_ccw     = '0;
    clr_key     = '0;
    for (int e = 0; e < NUM_ENC; e++) begin
      if (!grant_found && pend_cw[e]) begin
        grant_found = 1'b1;
        clr_cw[e]   = 1'b1;
        grant_event = make_event(EV_CW, EV_IDX_W'(e));
      end
      if (!grant_found && pend_ccw[e]) begin
        grant_found = 1'b1;
        clr_ccw[e]  = 1'b1;
        grant_event = make_event(EV_CCW, EV_IDX_W'(e));
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!grant_found && pend_key[k]) begin
        grant_found = 1'b1;
        clr_key[k]  = 1'b1;
        grant_event = make_event(pend_press[k] ? EV_PRESS : EV_RELEASE, EV_IDX_W'(k));
      end
    end
  end

  assign pop  = ev_rd && (level != '0);
  assign push = grant_found && ((level != FULL_LEVEL) || pop);

  // A new detent landing on an unserviced flag of the same direction is lost
  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      pend_cw    <= '0;
      pend_ccw   <= '0;
      pend_key   <= '0;
      pend_press <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_ENC; e++) begin
        if (det_cw[e]) begin
          if (pend_cw[e] && !(push && clr_cw[e])) overflow_q <= 1'b1;
          else                                    pend_cw[e] <= 1'b1;
        end else if (push && clr_cw[e]) begin
          pend_cw[e] <= 1'b0;
        end
        if (det_ccw[e]) begin
          if (pend_ccw[e] && !(push && clr_ccw[e])) overflow_q <= 1'b1;
          else                                      pend_ccw[e] <= 1'b1;
        end else if (push && clr_ccw[e]) begin
          pend_ccw[e] <= 1'b0;
        end
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_accept[k]) begin
          pend_key[k]   <= 1'b1;
          pend_press[k] <= ~key_stable[k];
        end else if (push && clr_key[k]) begin
          pend_key[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_event;
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  assign ev_valid   = (level != '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_level = level;
  assign overflow   = overflow_q;
  assign ev_data    = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_kbd_event_collector.sv
// Directed bench for kbd_event_collector with default parameters (32 keys, 4 encoders, depth 8).
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_kbd_event_collector;

  localparam int NUM_KEYS  = 32;
  localparam int NUM_ENC   = 4;
  localparam int DEB_TICKS = 8;
  localparam int FIFO_AW   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                scan_tick;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_ENC-1:0]  enc_a;
  logic [NUM_ENC-1:0]  enc_b;
  logic                fifo_clr;
  logic                ev_rd;
  logic [7:0]          ev_data;
  logic                ev_valid;
  logic                fifo_full;
  logic [FIFO_AW:0]    fifo_level;
  logic                overflow;

  int errors = 0;
  int checks = 0;

  kbd_event_collector #(
    .NUM_KEYS(NUM_KEYS), .NUM_ENC(NUM_ENC), .KEY_ACTIVE_LOW(1),
    .DEB_TICKS(DEB_TICKS), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .keys(keys),
    .enc_a(enc_a), .enc_b(enc_b), .fifo_clr(fifo_clr), .ev_rd(ev_rd),
    .ev_data(ev_data), .ev_valid(ev_valid), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) scan_tick = 1'b1;
      @(negedge clk) scan_tick = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(negedge clk) ev_rd = 1'b1;
    @(negedge clk) ev_rd = 1'b0;
  endtask

  task automatic enc_step(input int idx, input logic a, input logic b);
    @(negedge clk);
    enc_a[idx] = a;
    enc_b[idx] = b;
    idle(3);
  endtask

  task automatic enc_detent_cw(input int idx);
    enc_step(idx, 1'b1, 1'b0);
    enc_step(idx, 1'b1, 1'b1);
    enc_step(idx, 1'b0, 1'b1);
    enc_step(idx, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_tick = 1'b0; keys = '1; enc_a = '0; enc_b = '0;
    fifo_clr = 1'b0; ev_rd = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ev_valid); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (ev_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", ev_data); end
    checks++; if ({fifo_full, overflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {fifo_full, overflow}); end
  endtask

  task automatic test_key_press_release();
    @(negedge clk) keys[3] = 1'b0;
    idle(4);
    ticks(DEB_TICKS);
    idle(2);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("[TB] FAIL key3_press_valid: got %b expected 1", ev_valid); end
    @(negedge clk) keys[3] = 1'b1;
    idle(4);
    ticks(DEB_TICKS);
    idle(4);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("[TB] FAIL key3_level: got %0d expected 2", fifo_level); end
    checks++; if (ev_data !== 8'h43) begin errors++; $display("[TB] FAIL key3_press_code: got %h expected 43", ev_data); end
    pop_one();
    checks++; if (ev_data !== 8'h03) begin errors++; $display("[TB] FAIL key3_release_code: got %h expected 03", ev_data); end
    pop_one();
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL key3_drain_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_empty_read();
    pop_one();
    checks++; if ({ev_valid, fifo_level} !== 5'd0) begin errors++; $display("[TB] FAIL empty_read: got valid=%b level=%0d expected 0/0", ev_valid, fifo_level); end
  endtask

  task automatic test_glitch();
    @(negedge clk) keys[5] = 1'b0;
    idle(4);
    ticks(DEB_TICKS - 1);
    keys[5] = 1'b1;
    idle(4);
    ticks(DEB_TICKS);
    idle(4);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", ev_valid); end
  endtask

  task automatic test_encoder();
    enc_detent_cw(2);
    enc_step(2, 1'b0, 1'b1);
    enc_step(2, 1'b1, 1'b1);
    enc_step(2, 1'b1, 1'b0);
    enc_step(2, 1'b0, 1'b0);
    idle(3);
    checks++; if (fifo_level !== 4'd2) begin errors++; $display("[TB] FAIL enc2_level: got %0d expected 2", fifo_level); end
    checks++; if (ev_data !== 8'h82) begin errors++; $display("[TB] FAIL enc2_cw_code: got %h expected 82", ev_data); end
    pop_one();
    checks++; if (ev_data !== 8'hC2) begin errors++; $display("[TB] FAIL enc2_ccw_code: got %h expected c2", ev_data); end
    pop_one();
  endtask

  task automatic test_fill_order();
    logic [7:0] exp_code;
    @(negedge clk) keys[9:0] = '0;
    idle(4);
    ticks(DEB_TICKS);
    idle(15);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL fill_level: got %0d expected 8", fifo_level); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", fifo_full); end
    checks++; if (ev_data !== 8'h40) begin errors++; $display("[TB] FAIL fill_head: got %h expected 40", ev_data); end
    pop_one();
    pop_one();
    idle(2);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL refill_level: got %0d expected 8", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL refill_overflow: got %b expected 0", overflow); end
    for (int i = 2; i < 10; i++) begin
      exp_code = 8'h40 + 8'(i);
      checks++; if (ev_data !== exp_code) begin errors++; $display("[TB] FAIL fill_order_%0d: got %h expected %h", i, ev_data, exp_code); end
      pop_one();
    end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("[TB] FAIL fill_drain: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_full_overflow();
    @(negedge clk) keys[9:0] = '1;
    idle(4);
    ticks(DEB_TICKS);
    idle(15);
    enc_detent_cw(0);
    enc_detent_cw(0);
    idle(2);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow: got %b expected 1", overflow); end
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL full_level: got %0d expected 8", fifo_level); end
    checks++; if (ev_data !== 8'h00) begin errors++; $display("[TB] FAIL full_head: got %h expected 00", ev_data); end
    pop_one();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("[TB] FAIL pushpop_level: got %0d expected 8", fifo_level); end
    checks++; if (ev_data !== 8'h01) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected 01", ev_data); end
    @(negedge clk) fifo_clr = 1'b1;
    @(negedge clk) fifo_clr = 1'b0;
    checks++; if ({fifo_level, overflow} !== 5'd0) begin errors++; $display("[TB] FAIL clr_state: got level=%0d ovf=%b expected 0/0", fifo_level, overflow); end
    idle(5);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_held_dropped: got %b expected 0", ev_valid); end
  endtask

  task automatic test_mid_reset();
    enc_detent_cw(1);
    idle(3);
    checks++; if (ev_data !== 8'h81) begin errors++; $display("[TB] FAIL enc1_code: got %h expected 81", ev_data); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if ({ev_valid, fifo_full, overflow, fifo_level} !== 7'd0) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 0", {ev_valid, fifo_full, overflow, fifo_level}); end
    checks++; if (ev_data !== 8'h00) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 00", ev_data); end
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_key_press_release();
    test_empty_read();
    test_glitch();
    test_encoder();
    test_fill_order();
    test_full_overflow();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
